// File: rtl/tri_fifo_reader_if.sv
// Read side of the vertex FIFO plus the primitive valid/ready bus toward triangle setup.
interface tri_fifo_reader_if #(
    parameter int DBITS = 96,
    parameter int VERTS = 3
);
    logic                   fifo_empty;
    logic [DBITS-1:0]       fifo_dout;
    logic                   fifo_rd;
    logic                   tri_ready;
    logic                   tri_valid;
    logic [VERTS*DBITS-1:0] tri_data;

    // master is the reader: it pops the FIFO and sources primitives
    modport master (
        input  fifo_empty, fifo_dout, tri_ready,
        output fifo_rd, tri_valid, tri_data
    );

    modport slave (
        output fifo_empty, fifo_dout, tri_ready,
        input  fifo_rd, tri_valid, tri_data
    );
endinterface

// File: rtl/tri_fifo_reader.sv
// Pops VERTS vertex words from a show-ahead FIFO and emits them as one primitive on valid/ready.
// Define TRI_FIFO_READER_OVERLAP_EN to keep gathering while a finished primitive is held.
module tri_fifo_reader #(
    parameter int DBITS = 96,
    parameter int VERTS = 3,
    parameter int CBITS = 16
) (
    input  logic              clk,
    input  logic              reset,
    tri_fifo_reader_if.master bus,
    input  logic              flush,
    output logic              partial,
    output logic [CBITS-1:0]  tri_count
);
    localparam int            VW   = $clog2(VERTS);
    localparam logic [VW-1:0] LAST = VW'(VERTS - 1);

    typedef enum logic {GATHER = 1'b0, HOLD = 1'b1} state_t;

    state_t                      state;
    logic [VW-1:0]               vidx;
    logic [VERTS-2:0][DBITS-1:0] slot;
    logic                        valid_q;
    logic [VERTS*DBITS-1:0]      data_q;
    logic [VERTS*DBITS-1:0]      prim;
    logic                        pop;
    logic                        last_pop;
    logic                        hs;

`ifdef TRI_FIFO_READER_OVERLAP_EN
    // Only the closing pop must wait: it would overwrite a primitive not yet taken.
    assign pop = reset && !bus.fifo_empty && !flush &&
                 !((vidx == LAST) && valid_q && !bus.tri_ready);
`else
    assign pop = reset && !bus.fifo_empty && !flush && (state == GATHER);
`endif

    assign bus.fifo_rd   = pop;
    assign bus.tri_valid = valid_q;
    assign bus.tri_data  = data_q;
    assign last_pop      = pop && (vidx == LAST);
    assign hs            = (state == HOLD) && bus.tri_ready;
    assign partial       = (vidx != '0);

    // Slot 0 holds the first vertex; the closing vertex goes straight from the FIFO head.
    assign prim = {bus.fifo_dout, slot};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= GATHER;
            vidx      <= '0;
            slot      <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            tri_count <= '0;
        end else if (flush) begin
            state   <= GATHER;
            vidx    <= '0;
            valid_q <= 1'b0;
`ifdef TRI_FIFO_READER_OVERLAP_EN
            slot    <= '0;
`endif
        end else begin
            if (pop) begin
                vidx <= last_pop ? '0 : vidx + 1'b1;
                for (int k = 0; k < VERTS - 1; k++)
                    if (vidx == VW'(k)) slot[k] <= bus.fifo_dout;
            end
            if (last_pop) begin
                data_q  <= prim;
                valid_q <= 1'b1;
                state   <= HOLD;
            end else if (hs) begin
                valid_q <= 1'b0;
                state   <= GATHER;
            end
            if (hs) tri_count <= tri_count + 1'b1;
        end
    end
endmodule

// File: tb/tb_tri_fifo_reader.sv
// Randomized bench for tri_fifo_reader: FIFO model, primitive scoreboard and per-scenario timing checks.
module tb_tri_fifo_reader;
    localparam int DBITS = 96;
    localparam int VERTS = 3;
    localparam int CBITS = 4;
    localparam int PBITS = DBITS * VERTS;
`ifdef TRI_FIFO_READER_OVERLAP_EN
    localparam int PERIOD = VERTS;
    localparam int BP_POPS = 2;
`else
    localparam int PERIOD = VERTS + 1;
    localparam int BP_POPS = 0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             flush;
    logic             partial;
    logic [CBITS-1:0] tri_count;

    tri_fifo_reader_if #(.DBITS(DBITS), .VERTS(VERTS)) bus ();

    tri_fifo_reader #(.DBITS(DBITS), .VERTS(VERTS), .CBITS(CBITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .flush     (flush),
        .partial   (partial),
        .tri_count (tri_count)
    );

    always #5 clk = ~clk;

    int               total = 0;
    int               bad = 0;
    int               cyc = 0;
    int               viol = 0;
    logic [DBITS-1:0] q[$];
    logic [DBITS-1:0] ref_v[$];
    logic [PBITS-1:0] acc_q[$];
    int               acc_cyc[$];
    logic             obs_rd, obs_valid, obs_partial;
    logic [PBITS-1:0] obs_data;
    logic [CBITS-1:0] obs_count;
    logic [CBITS-1:0] exp_cnt;

    function automatic logic [DBITS-1:0] mkv();
        return {$urandom, $urandom, $urandom};
    endfunction

    function automatic logic [PBITS-1:0] pack3(input logic [DBITS-1:0] a, b, c);
        return {c, b, a};
    endfunction

    task automatic fifo_refresh();
        bus.fifo_empty = (q.size() == 0);
        bus.fifo_dout  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [DBITS-1:0] v);
        q.push_back(v);
        fifo_refresh();
    endtask

    // Sample one cycle at the falling edge, then advance past the rising edge.
    task automatic tick();
        logic [DBITS-1:0] tmp;
        @(negedge clk);
        obs_rd      = bus.fifo_rd;
        obs_valid   = bus.tri_valid;
        obs_data    = bus.tri_data;
        obs_partial = partial;
        obs_count   = tri_count;
        if (obs_rd && bus.fifo_empty) viol++;
        if (obs_valid && bus.tri_ready && !flush) begin
            acc_q.push_back(obs_data);
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (obs_rd) tmp = q.pop_front();
        fifo_refresh();
        cyc++;
    endtask

    task automatic test_reset();
        logic [DBITS-1:0] r0, r1, r2;
        r0 = mkv(); r1 = mkv(); r2 = mkv();
        bus.tri_ready = 1'b1;
        push(r0); push(r1);
        repeat (3) tick();
        total++; if (obs_rd !== 1'b0) begin bad++; $display("FAIL reset_rd: got %b want 0", obs_rd); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", obs_valid); end
        total++; if (obs_count !== '0) begin bad++; $display("FAIL reset_count: got %0d want 0", obs_count); end
        total++; if (obs_partial !== 1'b0) begin bad++; $display("FAIL reset_partial: got %b want 0", obs_partial); end
        total++; if (q.size() != 2) begin bad++; $display("FAIL reset_fifo_level: got %0d want 2", q.size()); end
        reset = 1'b1;
        tick();
        total++; if (obs_rd !== 1'b1) begin bad++; $display("FAIL reset_release_pop: got %b want 1", obs_rd); end
        tick(); tick();
        total++; if (obs_rd !== 1'b0) begin bad++; $display("FAIL reset_empty_rd: got %b want 0", obs_rd); end
        total++; if (obs_partial !== 1'b1) begin bad++; $display("FAIL reset_partial2: got %b want 1", obs_partial); end
        push(r2);
        ref_v.push_back(r0); ref_v.push_back(r1); ref_v.push_back(r2);
        tick(); tick();
        total++; if (obs_valid !== 1'b1 || obs_data !== pack3(r0, r1, r2)) begin
            bad++; $display("FAIL reset_first_prim: got v=%b %h want v=1 %h", obs_valid, obs_data, pack3(r0, r1, r2));
        end
        exp_cnt++;
        tick();
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL reset_count1: got %0d want %0d", obs_count, exp_cnt); end
    endtask

    task automatic test_basic();
        logic [DBITS-1:0] a, b, c;
        a = 96'h1; b = 96'h2; c = 96'h3;
        push(a); push(b); push(c);
        ref_v.push_back(a); ref_v.push_back(b); ref_v.push_back(c);
        bus.tri_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            total++; if (obs_rd !== (i <= 3)) begin bad++; $display("FAIL basic_rd c%0d: got %b want %b", i, obs_rd, (i <= 3)); end
            total++; if (obs_valid !== (i == 4)) begin bad++; $display("FAIL basic_valid c%0d: got %b want %b", i, obs_valid, (i == 4)); end
            if (i == 4) begin
                total++; if (obs_data !== pack3(a, b, c)) begin bad++; $display("FAIL basic_data: got %h want %h", obs_data, pack3(a, b, c)); end
            end
        end
        exp_cnt++;
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL basic_count: got %0d want %0d", obs_count, exp_cnt); end
    endtask

    task automatic test_backpressure();
        logic [DBITS-1:0] v[6];
        logic [PBITS-1:0] first;
        int n, pops, a0;
        for (int k = 0; k < 6; k++) begin v[k] = mkv(); push(v[k]); ref_v.push_back(v[k]); end
        bus.tri_ready = 1'b0;
        a0 = acc_q.size();
        n = 0;
        do begin tick(); n++; end while (!obs_valid && n < 12);
        total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL bp_first_valid: timed out after %0d cycles", n); end
        first = obs_data;
        total++; if (first !== pack3(v[0], v[1], v[2])) begin bad++; $display("FAIL bp_first_data: got %h want %h", first, pack3(v[0], v[1], v[2])); end
        pops = obs_rd ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            pops += obs_rd ? 1 : 0;
            total++; if (obs_valid !== 1'b1 || obs_data !== first) begin
                bad++; $display("FAIL bp_hold c%0d: got v=%b %h want v=1 %h", i, obs_valid, obs_data, first);
            end
        end
        total++; if (pops != BP_POPS) begin bad++; $display("FAIL bp_pops: got %0d want %0d", pops, BP_POPS); end
        bus.tri_ready = 1'b1;
        n = 0;
        while (acc_q.size() < a0 + 2 && n < 20) begin tick(); n++; end
        total++; if (acc_q.size() != a0 + 2) begin bad++; $display("FAIL bp_release: got %0d prims want %0d", acc_q.size() - a0, 2); end
        tick(); tick();
        exp_cnt += 2;
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL bp_count: got %0d want %0d", obs_count, exp_cnt); end
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", obs_valid); end
    endtask

    task automatic test_starved();
        logic [DBITS-1:0] v[3];
        bus.tri_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            v[j] = mkv();
            push(v[j]);
            ref_v.push_back(v[j]);
            tick();
            total++; if (obs_rd !== 1'b1) begin bad++; $display("FAIL starve_pop v%0d: got %b want 1", j, obs_rd); end
            for (int g = 0; g < 2; g++) begin
                tick();
                total++; if (obs_rd !== 1'b0) begin bad++; $display("FAIL starve_idle v%0d: got %b want 0", j, obs_rd); end
                total++; if (obs_partial !== (j < 2)) begin bad++; $display("FAIL starve_partial v%0d: got %b want %b", j, obs_partial, (j < 2)); end
                if (j == 2 && g == 0) begin
                    total++; if (obs_valid !== 1'b1 || obs_data !== pack3(v[0], v[1], v[2])) begin
                        bad++; $display("FAIL starve_prim: got v=%b %h want v=1 %h", obs_valid, obs_data, pack3(v[0], v[1], v[2]));
                    end
                end
            end
        end
        exp_cnt++;
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL starve_count: got %0d want %0d", obs_count, exp_cnt); end
    endtask

    task automatic test_flush();
        logic [DBITS-1:0] f[5];
        logic [DBITS-1:0] h;
        int n;
        for (int k = 0; k < 5; k++) begin f[k] = mkv(); push(f[k]); end
        bus.tri_ready = 1'b1;
        tick(); tick();
        total++; if (obs_rd !== 1'b1) begin bad++; $display("FAIL flush_prepop: got %b want 1", obs_rd); end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (obs_rd !== 1'b0) begin bad++; $display("FAIL flush_no_pop: got %b want 0", obs_rd); end
        total++; if (q.size() != 3) begin bad++; $display("FAIL flush_fifo_level: got %0d want 3", q.size()); end
        tick();
        total++; if (obs_partial !== 1'b0) begin bad++; $display("FAIL flush_partial: got %b want 0", obs_partial); end
        ref_v.push_back(f[2]); ref_v.push_back(f[3]); ref_v.push_back(f[4]);
        tick(); tick(); tick();
        total++; if (obs_valid !== 1'b1 || obs_data !== pack3(f[2], f[3], f[4])) begin
            bad++; $display("FAIL flush_prim: got v=%b %h want v=1 %h", obs_valid, obs_data, pack3(f[2], f[3], f[4]));
        end
        exp_cnt++;
        tick();
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL flush_count: got %0d want %0d", obs_count, exp_cnt); end
        // A held primitive is discarded even when ready arrives in the flush cycle.
        bus.tri_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin h = mkv(); push(h); end
        n = 0;
        do begin tick(); n++; end while (!obs_valid && n < 12);
        total++; if (obs_valid !== 1'b1) begin bad++; $display("FAIL flush_hold_valid: timed out after %0d cycles", n); end
        flush = 1'b1;
        bus.tri_ready = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        total++; if (obs_valid !== 1'b0) begin bad++; $display("FAIL flush_drop_valid: got %b want 0", obs_valid); end
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL flush_drop_count: got %0d want %0d", obs_count, exp_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [DBITS-1:0] v;
        int a0, n, span;
        bus.tri_ready = 1'b1;
        a0 = acc_q.size();
        for (int k = 0; k < 17 * VERTS; k++) begin v = mkv(); push(v); ref_v.push_back(v); end
        n = 0;
        while (acc_q.size() < a0 + 17 && n < 200) begin tick(); n++; end
        total++; if (acc_q.size() != a0 + 17) begin bad++; $display("FAIL b2b_stream: got %0d prims want 17", acc_q.size() - a0); end
        span = (acc_q.size() >= a0 + 17) ? acc_cyc[a0 + 16] - acc_cyc[a0] : -1;
        total++; if (span != 16 * PERIOD) begin bad++; $display("FAIL b2b_throughput: got %0d cycles want %0d", span, 16 * PERIOD); end
        tick(); tick();
        repeat (17) exp_cnt++;
        total++; if (obs_count !== exp_cnt) begin bad++; $display("FAIL b2b_wrap_count: got %0d want %0d", obs_count, exp_cnt); end
    endtask

    task automatic test_scoreboard();
        int np;
        np = ref_v.size() / VERTS;
        total++; if (acc_q.size() != np) begin bad++; $display("FAIL sb_prim_count: got %0d want %0d", acc_q.size(), np); end
        for (int i = 0; i < np && i < acc_q.size(); i++) begin
            total++; if (acc_q[i] !== pack3(ref_v[3 * i], ref_v[3 * i + 1], ref_v[3 * i + 2])) begin
                bad++; $display("FAIL sb_prim%0d: got %h want %h", i, acc_q[i], pack3(ref_v[3 * i], ref_v[3 * i + 1], ref_v[3 * i + 2]));
            end
        end
        total++; if (viol != 0) begin bad++; $display("FAIL rd_when_empty: got %0d events want 0", viol); end
    endtask

    initial begin
        flush          = 1'b0;
        bus.tri_ready  = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        exp_cnt        = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_starved();
        test_flush();
        test_back_to_back();
        test_scoreboard();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tri_fifo_reader.md
Name: tri_fifo_reader

Overview:
- Consumer end of the vertex FIFO (show-ahead, 96-bit entries, rd pops, dout valid whenever !empty).
- Pops consecutive vertex words and assembles them into one primitive of VERTS vertices.
- Presents each primitive to the rasterizer setup stage on a valid/ready interface.
- Sits between the vertex FIFO output and triangle setup.

Parameters:
- DBITS, 96, width of one vertex word (x,y,z 32b each); must match the FIFO's DBITS.
- VERTS, 3, vertices per primitive; legal range 2..4.
- CBITS, 16, width of the emitted-primitive counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fifo_empty  in  1  FIFO empty flag.
- fifo_dout  in  DBITS  FIFO head entry; valid when fifo_empty=0.
- fifo_rd  out  1  pop strobe to FIFO; combinational.
- flush  in  1  synchronous; discards partial and held primitive.
- tri_ready  in  1  downstream accepts primitive.
- tri_valid  out  1  primitive available; registered.
- tri_data  out  VERTS*DBITS  vertex k at bits [k*DBITS +: DBITS]; registered.
- partial  out  1  1 while 0 < gathered vertices < VERTS.
- tri_count  out  CBITS  primitives accepted downstream, wraps modulo 2^CBITS.

Behaviour:
- Reset (reset=0, async): tri_valid=0, tri_data=0, tri_count=0, partial=0, vertex index vidx=0, state=GATHER.
  - fifo_rd is forced 0 while reset=0.
- States:
  - GATHER: fifo_rd = !fifo_empty && !flush.
    - On each pop, fifo_dout is stored in slot vidx and vidx increments.
    - Pop with vidx==VERTS-1: vidx returns to 0, tri_data loads all VERTS slots (last one direct from fifo_dout), state goes to HOLD.
  - HOLD: tri_valid=1.
    - fifo_rd=0 (base mode).
    - tri_data is held stable while tri_ready=0.
    - tri_valid && tri_ready: handshake, tri_count increments, tri_valid=0 next cycle, state goes to GATHER.
- Latency: final vertex popped in cycle N gives tri_valid=1 in cycle N+1. Base throughput is one primitive per VERTS+1 cycles.
- Vertex order: the first popped vertex lands in slot 0.
- fifo_empty=1 in GATHER: no pop, vidx holds, partial reflects vidx!=0. No timeout.
- flush=1 (any state):
  - Next cycle: vidx=0, tri_valid=0, state=GATHER.
  - fifo_rd=0 in the flush cycle; no entry is lost from the FIFO.
  - tri_count is unchanged, even if tri_ready=1 in the same cycle; flush wins.
- tri_count wraps from 2^CBITS-1 to 0 silently.
- tri_valid never drops without a handshake, except for flush or reset.
- fifo_rd is never asserted when fifo_empty=1.

Optional Feature:
- Macro: TRI_FIFO_READER_OVERLAP_EN.
- Defined:
  - Gathering continues during HOLD, into VERTS-1 staging slots separate from tri_data.
  - fifo_rd = !fifo_empty && !flush && !(vidx==VERTS-1 && tri_valid && !tri_ready).
  - Final pop in the same cycle as a handshake: tri_valid stays 1 next cycle with the new primitive, and tri_count increments.
  - Sustained throughput is one primitive per VERTS cycles.
  - flush also clears the staging slots.
- Undefined: base behaviour above; no staging logic is instantiated.

Test Plan:
- Reset: hold reset=0 with FIFO holding 2 entries, tri_ready=1 -> fifo_rd=0, tri_valid=0, tri_count=0. After release, pops begin the next cycle.
- Basic primitive: FIFO preloaded A=96'h1, B=96'h2, C=96'h3, tri_ready=1 -> fifo_rd=1 for cycles 1-3; tri_valid=1 in cycle 4 with tri_data={C,B,A}; tri_count=1 in cycle 5.
- Backpressure: 6 entries, tri_ready=0 for 5 cycles after first tri_valid ->
  - Base: fifo_rd=0 throughout HOLD, tri_data stable.
  - OVERLAP_EN: exactly 2 pops, then stall.
  - Release: second primitive follows; tri_count=2.
- Starved input: vertices written with 2-cycle gaps -> pops only when fifo_empty=0; partial=1 between vertex 1 and vertex 3; primitive identical to the gapless case.
- Flush: pop 2 vertices, pulse flush with fifo_empty=0 -> no pop that cycle, partial=0. The next 3 entries form the primitive (slot 0 = third FIFO entry); tri_count unchanged by flush.
- Wrap: CBITS=4, stream 17 primitives with tri_ready=1 -> tri_count=1 at end, no dropped or duplicated vertices (scoreboard compare).
